// File: rtl/onchip_read_master_stream_if.sv
// Avalon-MM read bus plus the outbound valid/ready word stream of the read master.
// The slave modport is the memory/consumer side of the same signals.
interface onchip_read_master_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic                    chipselect;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_valid;
  logic                    data_ready;

  modport master (
    output address, byteenable, read, chipselect,
    input  waitrequest, readdata, readdatavalid,
    output data_out, data_valid,
    input  data_ready
  );

  modport slave (
    input  address, byteenable, read, chipselect,
    output waitrequest, readdata, readdatavalid,
    input  data_out, data_valid,
    output data_ready
  );
endinterface

// File: rtl/onchip_read_master_stream.sv
// Block read master: pipelined Avalon-MM reads of NUM words from a base address,
// buffered in a first-word-fall-through FIFO and streamed out with valid/ready.
module onchip_read_master_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 11,
  parameter int LEN_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  onchip_read_master_stream_if.master bus,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  protocol_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CW:0]           DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_C = ADDR_WIDTH'(ADDR_STRIDE);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic credit, rd_req, accept, push, pop;

  always_comb begin
    // Credit counts words already in flight, so every accepted read has a FIFO slot reserved.
    credit = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
    rd_req = (state_q == S_ISSUE) && credit;
    accept = rd_req && !bus.waitrequest;
    push   = bus.readdatavalid && (outstanding_q != '0);
    pop    = (count_q != '0) && bus.data_ready;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    done_d        = 1'b0;
    perr_d        = perr_q | (bus.readdatavalid && (outstanding_q == '0));
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({accept, push})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = start_addr;
          rem_d  = num_words;
          if (num_words == '0) done_d  = 1'b1;
          else                 state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d = addr_q + STRIDE_C;
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((outstanding_q == '0) && (count_q == '0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      done_q        <= done_d;
      perr_q        <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.readdata;
  end

  assign bus.address    = addr_q;
  assign bus.byteenable = '1;
  assign bus.read       = rd_req;
  assign bus.chipselect = rd_req;
  assign bus.data_out   = mem_q[rd_ptr_q];
  assign bus.data_valid = (count_q != '0);
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign protocol_err   = perr_q;
endmodule

// File: tb/tb_onchip_read_master_stream.sv
// Randomised bench for the block read master: an Avalon slave with variable wait and
// in-order variable latency, and a word-level expectation of addresses and streamed data.
module tb_onchip_read_master_stream;
  localparam int DW = 16, AW = 11, LW = 12, FD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy, done, protocol_err;
  logic          start2 = 1'b0;
  logic [AW-1:0] start_addr2 = '0;
  logic [LW-1:0] num_words2 = '0;
  logic          busy2, done2, protocol_err2;

  onchip_read_master_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  onchip_read_master_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  onchip_read_master_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .FIFO_DEPTH(FD), .ADDR_STRIDE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start), .start_addr(start_addr),
    .num_words(num_words), .busy(busy), .done(done), .protocol_err(protocol_err));

  onchip_read_master_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .FIFO_DEPTH(FD), .ADDR_STRIDE(2)) u_dut_stride2 (
    .clk(clk), .rst(rst), .bus(bus2), .start(start2), .start_addr(start_addr2),
    .num_words(num_words2), .busy(busy2), .done(done2), .protocol_err(protocol_err2));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return ({5'd0, a} * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Reference: the ordered list of addresses a transfer must issue and the words it must stream.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  typedef struct { logic [DW-1:0] d; int due; } rsp_t;
  rsp_t slv_q [$];
  int last_due = 0;
  int lat_min = 1, lat_max = 1;
  int wr_mode = 0, ready_mode = 1;
  logic [AW-1:0] stall_addr = '0;
  int stall_left = 0, stall_seen = 0;

  int acc_cnt = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  int first_read_cyc = -1, first_valid_cyc = -1, s_cyc = 0;
  logic [DW-1:0] first_data = '0;
  bit dv_seen = 0;
  bit prev_stall = 0, prev_hold = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  // Slave side: waitrequest, in-order responses, consumer ready.
  initial begin
    bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0; bus.data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        1: bus.waitrequest = ($urandom_range(0, 3) == 0);
        2: if (bus.read && bus.address == stall_addr && stall_left > 0) begin
             bus.waitrequest = 1'b1; stall_left--;
           end else bus.waitrequest = 1'b0;
        default: bus.waitrequest = 1'b0;
      endcase
      case (ready_mode)
        0: bus.data_ready = 1'b0;
        1: bus.data_ready = 1'b1;
        default: bus.data_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
        bus.readdatavalid = 1'b1;
        bus.readdata = slv_q[0].d;
        void'(slv_q.pop_front());
      end else begin
        bus.readdatavalid = 1'b0;
        bus.readdata = DW'($urandom);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int lat, due;
    if (!rst) begin
      chk("chipselect_eq_read", bus.chipselect, bus.read);
      chk("byteenable", bus.byteenable, 2'b11);
      if (prev_stall) begin
        chk("stall_read_held", bus.read, 1);
        chk("stall_addr_held", bus.address, prev_addr);
      end
      if (prev_hold) begin
        chk("hold_valid", bus.data_valid, 1);
        chk("hold_data", bus.data_out, prev_data);
      end
      if (bus.read && first_read_cyc < 0) first_read_cyc = cyc;
      if (bus.read && bus.waitrequest && bus.address == stall_addr) stall_seen++;
      if (bus.read && !bus.waitrequest) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        if (exp_addr.size() == 0) fail("extra_read");
        else chk("read_addr", bus.address, exp_addr.pop_front());
      end
      if (bus.data_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        first_data = bus.data_out;
      end
      if (bus.data_valid && bus.data_ready) begin
        if (exp_data.size() == 0) fail("extra_data");
        else chk("data_out", bus.data_out, exp_data.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_in_done", busy, 0);
      end
      prev_stall = bus.read && bus.waitrequest;
      prev_addr  = bus.address;
      prev_hold  = bus.data_valid && !bus.data_ready;
      prev_data  = bus.data_out;
    end else begin
      prev_stall = 0;
      prev_hold  = 0;
    end
    if (bus.data_valid) dv_seen = 1;
    if (bus.read && !bus.waitrequest) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      slv_q.push_back('{d: mem_word(bus.address), due: due});
    end
  end

  // Minimal zero-wait, latency-1 slave for the stride-2 instance.
  logic [AW-1:0] addr2_q [$];
  logic [DW-1:0] data2_q [$];
  int done2_cnt = 0;
  initial begin
    bit pend2;
    logic [AW-1:0] pend_addr;
    pend2 = 0; pend_addr = '0;
    bus2.waitrequest = 1'b0; bus2.readdatavalid = 1'b0; bus2.readdata = '0; bus2.data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus2.readdatavalid = pend2;
      bus2.readdata = pend2 ? mem_word(pend_addr) : '0;
      pend2 = 0;
      @(negedge clk);
      if (!rst && bus2.read) begin
        pend2 = 1; pend_addr = bus2.address; addr2_q.push_back(bus2.address);
      end
      if (!rst && bus2.data_valid) data2_q.push_back(bus2.data_out);
      if (!rst && done2) done2_cnt++;
    end
  end

  task automatic start_xfer(input logic [AW-1:0] a, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'(a + AW'(i)));
      exp_data.push_back(mem_word(AW'(a + AW'(i))));
    end
    done_cnt = 0; acc_cnt = 0; first_read_cyc = -1; first_valid_cyc = -1;
    s_cyc = cyc;
    start = 1'b1; start_addr = a; num_words = LW'(n);
    @(posedge clk); #1;
    start = 1'b0; start_addr = AW'($urandom); num_words = LW'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin @(posedge clk); #1; k++; end
    if (done_cnt == 0) fail({tag, "_done_timeout"});
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_addr_left"}, exp_addr.size(), 0);
    chk({tag, "_data_left"}, exp_data.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_read_after"}, bus.read, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", bus.read, 0);
    chk("rst_chipselect", bus.chipselect, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    rst = 1'b0;

    // Basic block read with latency pinned to literal cycles and a literal first word.
    wr_mode = 0; ready_mode = 1; lat_min = 1; lat_max = 1;
    start_xfer(11'h010, 4);
    wait_done("basic");
    chk("basic_first_read", first_read_cyc - s_cyc, 1);
    chk("basic_last_accept", last_acc_cyc - s_cyc, 4);
    chk("basic_first_valid", first_valid_cyc - s_cyc, 3);
    chk("basic_first_word", first_data, 16'h4A4A);

    // Backpressure: with the consumer stalled only FIFO_DEPTH reads may be granted.
    ready_mode = 0;
    start_xfer(11'h200, 20);
    repeat (28) @(posedge clk);
    #1;
    chk("bp_reads_in_stall", acc_cnt, 8);
    ready_mode = 1;
    wait_done("bp");

    // Waitrequest held for 3 cycles on the second word.
    wr_mode = 2; stall_addr = 11'h011; stall_left = 3; stall_seen = 0; lat_min = 1; lat_max = 2;
    start_xfer(11'h010, 5);
    wait_done("wait");
    chk("wait_stall_cycles", stall_seen, 3);
    stall_addr = 11'h7FF;

    // Zero-length command.
    wr_mode = 0;
    start_xfer(11'h123, 0);
    wait_done("zero");
    chk("zero_done_latency", done_cyc - s_cyc, 1);
    chk("zero_reads", acc_cnt, 0);

    // Random transfers; some see a start pulse while busy, which must be ignored.
    wr_mode = 1; ready_mode = 2; lat_min = 1; lat_max = 4;
    for (int t = 0; t < 8; t++) begin
      start_xfer(AW'($urandom), (t % 2 == 1) ? int'($urandom_range(5, 24)) : int'($urandom_range(1, 24)));
      if (t % 2 == 1) begin
        repeat (1) @(posedge clk);
        #1;
        if (busy) begin
          start = 1'b1; start_addr = AW'($urandom); num_words = LW'($urandom_range(1, 9));
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      wait_done("rand");
    end
    chk("perr_clean", protocol_err, 0);

    // Reset with reads in flight: late responses must be dropped and flagged.
    wr_mode = 0; ready_mode = 1; lat_min = 5; lat_max = 5;
    start_xfer(11'h300, 8);
    k = 0;
    while (acc_cnt < 2 && k < 50) begin @(posedge clk); #1; k++; end
    if (acc_cnt < 2) fail("rst_test_no_reads");
    rst = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    dv_seen = 0;
    chk("midrst_read_low", bus.read, 0);
    chk("midrst_busy_low", busy, 0);
    k = 0;
    while (slv_q.size() > 0 && k < 50) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_data", dv_seen, 0);
    chk("midrst_perr", protocol_err, 1);
    lat_min = 1; lat_max = 3;
    start_xfer(11'h040, 2);
    wait_done("post_rst");
    chk("perr_sticky", protocol_err, 1);

    // Stride-2 instance: wrap from the top of the address space.
    @(posedge clk); #1;
    start2 = 1'b1; start_addr2 = 11'h7FE; num_words2 = 12'd3;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 0;
    while (done2_cnt == 0 && k < 100) begin @(posedge clk); #1; k++; end
    if (done2_cnt == 0) fail("stride_done_timeout");
    chk("stride_reads", addr2_q.size(), 3);
    chk("stride_words", data2_q.size(), 3);
    if (addr2_q.size() >= 3 && data2_q.size() >= 3) begin
      chk("stride_addr0", addr2_q[0], 11'h7FE);
      chk("stride_addr1", addr2_q[1], 11'h000);
      chk("stride_addr2", addr2_q[2], 11'h002);
      chk("stride_data0", data2_q[0], mem_word(11'h7FE));
      chk("stride_data1", data2_q[1], 16'h5A5A);
      chk("stride_data2", data2_q[2], mem_word(11'h002));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
